// File: rtl/ttt_board_ctrl.sv
// rtl/ttt_board_ctrl.sv - tic-tac-toe board, turn and verdict controller
// Optional single-level undo history is built only when TTT_UNDO_EN is defined.
module ttt_board_ctrl #(
  parameter logic FIRST_PLAYER = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       new_game,
  input  logic       move_valid,
  input  logic [3:0] move_pos,
  output logic       move_ready,
  input  logic       undo,
  input  logic       x_win_in,
  input  logic       o_win_in,
  output logic [8:0] board_x,
  output logic [8:0] board_o,
  output logic       turn,
  output logic [3:0] move_count,
  output logic       illegal_move,
  output logic       game_over,
  output logic [1:0] winner
);

  typedef enum logic [1:0] {
    S_PLAY  = 2'd0,
    S_CHECK = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t     state;
  logic [8:0] pos_mask;
  logic       cell_free;
  logic       take_undo;

  // pos_mask is all-zero for positions 9..15, which makes them illegal for free
  always_comb begin
    pos_mask = 9'd0;
    for (int i = 0; i < 9; i++) begin
      pos_mask[i] = (move_pos == 4'(i));
    end
  end

  assign cell_free = (pos_mask != 9'd0) && ((pos_mask & (board_x | board_o)) == 9'd0);

`ifdef TTT_UNDO_EN
  logic       hist_valid;
  logic [8:0] hist_mask;
  logic       hist_player;

  assign take_undo = undo && hist_valid;

  always_ff @(posedge clk) begin
    if (rst || new_game) begin
      hist_valid  <= 1'b0;
      hist_mask   <= 9'd0;
      hist_player <= 1'b0;
    end else if (state == S_PLAY) begin
      if (take_undo) begin
        hist_valid <= 1'b0;
      end else if (move_valid && cell_free) begin
        hist_valid  <= 1'b1;
        hist_mask   <= pos_mask;
        hist_player <= turn;
      end
    end
  end
`else
  logic unused_undo;
  assign unused_undo = undo;
  assign take_undo   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst || new_game) begin
      state        <= S_PLAY;
      board_x      <= 9'd0;
      board_o      <= 9'd0;
      turn         <= FIRST_PLAYER;
      move_count   <= 4'd0;
      illegal_move <= 1'b0;
      game_over    <= 1'b0;
      winner       <= 2'b00;
      move_ready   <= 1'b1;
    end else begin
      illegal_move <= 1'b0;
      case (state)
        S_PLAY: begin
          if (take_undo) begin
`ifdef TTT_UNDO_EN
            if (hist_player) begin
              board_o <= board_o & ~hist_mask;
            end else begin
              board_x <= board_x & ~hist_mask;
            end
            move_count <= move_count - 4'd1;
            turn       <= hist_player;
`endif
          end else if (move_valid) begin
            if (cell_free) begin
              if (turn) begin
                board_o <= board_o | pos_mask;
              end else begin
                board_x <= board_x | pos_mask;
              end
              move_count <= move_count + 4'd1;
              state      <= S_CHECK;
              move_ready <= 1'b0;
            end else begin
              illegal_move <= 1'b1;
            end
          end
        end
        // detector inputs now reflect the board written on the previous edge
        S_CHECK: begin
          if (x_win_in) begin
            winner    <= 2'b01;
            game_over <= 1'b1;
            state     <= S_DONE;
          end else if (o_win_in) begin
            winner    <= 2'b10;
            game_over <= 1'b1;
            state     <= S_DONE;
          end else if (move_count == 4'd9) begin
            winner    <= 2'b11;
            game_over <= 1'b1;
            state     <= S_DONE;
          end else begin
            turn       <= ~turn;
            move_ready <= 1'b1;
            state      <= S_PLAY;
          end
        end
        S_DONE: begin
          game_over  <= 1'b1;
          move_ready <= 1'b0;
        end
        default: begin
          state      <= S_PLAY;
          move_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ttt_board_ctrl.sv
// tb/tb_ttt_board_ctrl.sv - self-checking bench for ttt_board_ctrl
// Cell-array game model plus an external three-in-a-row detector.
module tb_ttt_board_ctrl;

  logic       clk = 1'b0;
  logic       rst, new_game, move_valid, undo;
  logic [3:0] move_pos;
  logic       move_ready, x_win_in, o_win_in, turn, illegal_move, game_over;
  logic [8:0] board_x, board_o;
  logic [3:0] move_count;
  logic [1:0] winner;

  int checks = 0;
  int errors = 0;

  int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                       '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  always #5 clk = ~clk;

  ttt_board_ctrl dut (
    .clk(clk), .rst(rst), .new_game(new_game), .move_valid(move_valid),
    .move_pos(move_pos), .move_ready(move_ready), .undo(undo),
    .x_win_in(x_win_in), .o_win_in(o_win_in), .board_x(board_x),
    .board_o(board_o), .turn(turn), .move_count(move_count),
    .illegal_move(illegal_move), .game_over(game_over), .winner(winner)
  );

  function automatic logic has_line(input logic [8:0] b);
    has_line = 1'b0;
    for (int i = 0; i < 8; i++)
      if (b[lines[i][0]] && b[lines[i][1]] && b[lines[i][2]]) has_line = 1'b1;
  endfunction

  assign x_win_in = has_line(board_x);
  assign o_win_in = has_line(board_o);

  // reference model: 0 empty, 1 X, 2 O
  int         m_cell [9];
  logic       m_turn;
  int         m_count;
  logic       m_over;
  logic [1:0] m_winner;
  logic       m_ill;
  logic       ill_t1, rdy_t1;

  function automatic logic [8:0] m_board(input int who);
    m_board = 9'd0;
    for (int i = 0; i < 9; i++) if (m_cell[i] == who) m_board[i] = 1'b1;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 9; i++) m_cell[i] = 0;
    m_turn = 1'b0; m_count = 0; m_over = 1'b0; m_winner = 2'b00; m_ill = 1'b0;
  endtask

  task automatic m_move(input int pos);
    m_ill = 1'b0;
    if (m_over) return;
    if (pos > 8) begin m_ill = 1'b1; return; end
    if (m_cell[pos] != 0) begin m_ill = 1'b1; return; end
    m_cell[pos] = m_turn ? 2 : 1;
    m_count++;
    if (has_line(m_board(1)))      begin m_over = 1'b1; m_winner = 2'b01; end
    else if (has_line(m_board(2))) begin m_over = 1'b1; m_winner = 2'b10; end
    else if (m_count == 9)         begin m_over = 1'b1; m_winner = 2'b11; end
    else m_turn = ~m_turn;
  endtask

  // entered and left at a falling edge; two cycles per request
  task automatic play(input int pos);
    move_valid = 1'b1; move_pos = 4'(pos);
    @(negedge clk);
    ill_t1 = illegal_move; rdy_t1 = move_ready;
    move_valid = 1'b0;
    @(negedge clk);
    m_move(pos);
  endtask

  task automatic start_game();
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    m_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1; new_game = 1'b0; move_valid = 1'b0; undo = 1'b0; move_pos = 4'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    m_reset();
    checks++; if (board_x !== 9'd0 || board_o !== 9'd0) begin errors++; $display("FAIL reset_boards got %h/%h exp 0/0", board_x, board_o); end
    checks++; if (turn !== 1'b0 || move_count !== 4'd0) begin errors++; $display("FAIL reset_turn_count got %b/%0d exp 0/0", turn, move_count); end
    checks++; if ({move_ready, game_over, winner, illegal_move} !== 5'b10000) begin errors++; $display("FAIL reset_flags got %b exp 10000", {move_ready, game_over, winner, illegal_move}); end
  endtask

  task automatic test_x_win();
    int seq [5] = '{0, 3, 1, 4, 2};
    start_game();
    foreach (seq[i]) play(seq[i]);
    checks++; if (winner !== 2'b01 || game_over !== 1'b1) begin errors++; $display("FAIL x_win_verdict got %b/%b exp 01/1", winner, game_over); end
    checks++; if (board_x !== 9'h007 || board_o !== 9'h018) begin errors++; $display("FAIL x_win_boards got %h/%h exp 007/018", board_x, board_o); end
    checks++; if (turn !== 1'b0 || move_ready !== 1'b0) begin errors++; $display("FAIL x_win_turn_ready got %b/%b exp 0/0", turn, move_ready); end
    play(8);
    checks++; if (ill_t1 !== 1'b0 || board_x !== 9'h007 || move_count !== 4'd5) begin errors++; $display("FAIL done_ignores_move got ill=%b x=%h cnt=%0d exp 0/007/5", ill_t1, board_x, move_count); end
  endtask

  task automatic test_illegal();
    start_game();
    play(4);
    checks++; if (rdy_t1 !== 1'b0) begin errors++; $display("FAIL check_ready got %b exp 0", rdy_t1); end
    play(4);
    checks++; if (ill_t1 !== 1'b1 || illegal_move !== 1'b0) begin errors++; $display("FAIL occupied_pulse got %b,%b exp 1,0", ill_t1, illegal_move); end
    checks++; if (board_o !== 9'd0 || turn !== 1'b1 || move_count !== 4'd1) begin errors++; $display("FAIL occupied_state got o=%h t=%b c=%0d exp 0/1/1", board_o, turn, move_count); end
    play(12);
    checks++; if (ill_t1 !== 1'b1 || illegal_move !== 1'b0) begin errors++; $display("FAIL range_pulse got %b,%b exp 1,0", ill_t1, illegal_move); end
    checks++; if (board_x !== 9'h010 || board_o !== 9'd0 || move_count !== 4'd1 || move_ready !== 1'b1) begin errors++; $display("FAIL range_state got x=%h o=%h c=%0d r=%b exp 010/0/1/1", board_x, board_o, move_count, move_ready); end
  endtask

  task automatic test_back_to_back();
    int seq [4] = '{0, 3, 1, 4};
    start_game();
    for (int k = 0; k < 8; k++) begin
      move_valid = 1'b1; move_pos = 4'(seq[k / 2]);
      @(negedge clk);
      checks++; if (move_ready !== (k % 2 == 1) || illegal_move !== 1'b0) begin errors++; $display("FAIL b2b_ready_%0d got r=%b ill=%b exp r=%b ill=0", k, move_ready, illegal_move, (k % 2 == 1)); end
    end
    move_valid = 1'b0;
    checks++; if (board_x !== 9'h003 || board_o !== 9'h018 || move_count !== 4'd4 || turn !== 1'b0) begin errors++; $display("FAIL b2b_state got x=%h o=%h c=%0d t=%b exp 003/018/4/0", board_x, board_o, move_count, turn); end
  endtask

  task automatic test_draw();
    int seq [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
    start_game();
    foreach (seq[i]) play(seq[i]);
    checks++; if (winner !== 2'b11 || move_count !== 4'd9 || move_ready !== 1'b0 || game_over !== 1'b1) begin errors++; $display("FAIL draw got w=%b c=%0d r=%b g=%b exp 11/9/0/1", winner, move_count, move_ready, game_over); end
  endtask

  task automatic test_new_game();
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    checks++; if (board_x !== 9'd0 || board_o !== 9'd0 || move_count !== 4'd0 || turn !== 1'b0 || winner !== 2'b00 || move_ready !== 1'b1) begin errors++; $display("FAIL newgame_done got x=%h o=%h c=%0d t=%b w=%b r=%b", board_x, board_o, move_count, turn, winner, move_ready); end
    m_reset();
    play(0); play(1); play(2); play(4);
    move_valid = 1'b1; move_pos = 4'd3;
    @(negedge clk);
    move_valid = 1'b0; new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    m_reset();
    checks++; if (board_x !== 9'd0 || board_o !== 9'd0 || move_count !== 4'd0 || turn !== 1'b0 || winner !== 2'b00 || move_ready !== 1'b1) begin errors++; $display("FAIL newgame_check got x=%h o=%h c=%0d t=%b w=%b r=%b", board_x, board_o, move_count, turn, winner, move_ready); end
    @(negedge clk);
    checks++; if (game_over !== 1'b0 || move_ready !== 1'b1) begin errors++; $display("FAIL newgame_abort got g=%b r=%b exp 0/1", game_over, move_ready); end
  endtask

  task automatic test_random_games();
    int pos;
    for (int g = 0; g < 12; g++) begin
      start_game();
      for (int n = 0; n < 24 && !m_over; n++) begin
        pos = ($urandom_range(0, 9) == 0) ? int'($urandom_range(9, 15)) : int'($urandom_range(0, 8));
        play(pos);
        checks++; if (ill_t1 !== m_ill) begin errors++; $display("FAIL rnd_illegal g%0d got %b exp %b", g, ill_t1, m_ill); end
        checks++; if (board_x !== m_board(1) || board_o !== m_board(2)) begin errors++; $display("FAIL rnd_boards g%0d got %h/%h exp %h/%h", g, board_x, board_o, m_board(1), m_board(2)); end
        checks++; if (turn !== m_turn || move_count !== 4'(m_count)) begin errors++; $display("FAIL rnd_turn_count g%0d got %b/%0d exp %b/%0d", g, turn, move_count, m_turn, m_count); end
        checks++; if (game_over !== m_over || winner !== m_winner || move_ready !== !m_over) begin errors++; $display("FAIL rnd_verdict g%0d got g=%b w=%b r=%b exp %b/%b/%b", g, game_over, winner, move_ready, m_over, m_winner, !m_over); end
      end
    end
  endtask

`ifdef TTT_UNDO_EN
  task automatic test_undo();
    start_game();
    play(4);
    undo = 1'b1;
    @(negedge clk);
    undo = 1'b0;
    checks++; if (board_x !== 9'd0 || move_count !== 4'd0 || turn !== 1'b0) begin errors++; $display("FAIL undo_first got x=%h c=%0d t=%b exp 0/0/0", board_x, move_count, turn); end
    undo = 1'b1;
    @(negedge clk);
    undo = 1'b0;
    checks++; if (board_x !== 9'd0 || move_count !== 4'd0 || turn !== 1'b0 || move_ready !== 1'b1) begin errors++; $display("FAIL undo_second got x=%h c=%0d t=%b r=%b", board_x, move_count, turn, move_ready); end
    play(4);
    undo = 1'b1; move_valid = 1'b1; move_pos = 4'd0;
    @(negedge clk);
    undo = 1'b0; move_valid = 1'b0;
    @(negedge clk);
    checks++; if (board_x !== 9'd0 || board_o !== 9'd0 || move_count !== 4'd0 || turn !== 1'b0) begin errors++; $display("FAIL undo_drop got x=%h o=%h c=%0d t=%b exp 0/0/0/0", board_x, board_o, move_count, turn); end
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_x_win();
    test_illegal();
    test_back_to_back();
    test_draw();
    test_new_game();
    test_random_games();
`ifdef TTT_UNDO_EN
    test_undo();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
